upg_word_writer: RTL and testbench
==================================

UPG_WORD_WRITER -- requirements
Module: upg_word_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning the width of the program-memory word address.
REQ-002 SHALL have parameter TIMEOUT, default 100000, meaning the idle clock cycles allowed between bytes inside a frame.
REQ-003 SHALL have port upg_clk_i  input  1  programmer clock (10 MHz); the only clock.
REQ-004 SHALL have port upg_rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_data_i  input  8  received UART byte.
REQ-006 SHALL have port rx_valid_i  input  1  one-cycle strobe; rx_data_i is valid in that cycle.
REQ-007 SHALL have port upg_wen_o  output  1  program-memory write enable, one-cycle pulse per word.
REQ-008 SHALL have port upg_adr_o  output  ADDR_W  word address for the write.
REQ-009 SHALL have port upg_dat_o  output  32  word data for the write.
REQ-010 SHALL have port upg_done_o  output  1  all words written; held high.
REQ-011 SHALL have port busy_o  output  1  a frame is in progress (state CNT_HI or DATA).
REQ-012 SHALL have port err_o  output  1  sticky flag for a bad count or timeout; cleared when the next frame starts.

Function
REQ-013 SHALL accept frames of the form: count LSB, count MSB (16-bit word count N, little-endian), then 4*N data bytes, each word little-endian (first byte goes to bits [7:0]).
REQ-014 SHALL implement the states IDLE, CNT_HI, DATA and DONE.
REQ-015 IDLE, on rx_valid_i: SHALL latch the count LSB, clear err_o, and go to CNT_HI.
REQ-016 CNT_HI, on rx_valid_i: SHALL form N.
REQ-017 In CNT_HI, if N==0 or N>2^ADDR_W, SHALL set err_o and return to IDLE.
REQ-018 In CNT_HI, for a legal N, SHALL clear the word index, byte index and address, then go to DATA.
REQ-019 DATA: SHALL shift each accepted byte into an internal assembly register, and the byte index SHALL wrap 3->0.
REQ-020 On the cycle after the 4th byte of a word is accepted, SHALL drive upg_wen_o=1 for exactly one cycle, upg_dat_o=the assembled word, and upg_adr_o=the word index.
REQ-021 upg_adr_o and upg_dat_o SHALL hold their values until the next write.
REQ-022 The word index SHALL increment after each write.
REQ-023 When the write of word N-1 is issued, SHALL go to DONE.
REQ-024 upg_done_o SHALL rise in the cycle after that write pulse and stay high until reset.
REQ-025 DONE SHALL ignore all rx bytes, and upg_wen_o SHALL never assert in DONE.
REQ-026 A byte accepted during a write-pulse cycle SHALL enter the assembly register without changing upg_dat_o or upg_adr_o in that cycle.
REQ-027 The timeout counter SHALL clear on every accepted byte and on every state change, and SHALL count only in CNT_HI and DATA.
REQ-028 When the timeout counter reaches TIMEOUT-1 with no byte, SHALL set err_o and go to IDLE.
REQ-029 When the timeout and rx_valid_i occur in the same cycle, SHALL accept the byte and SHALL NOT raise the timeout.
REQ-030 A partially written frame after a timeout SHALL NOT be rolled back, and upg_done_o SHALL stay 0.
REQ-031 SHALL have a minimum byte spacing of 1 cycle, so back-to-back rx_valid_i SHALL be accepted every cycle.

Reset
REQ-032 While upg_rstn_i=0, SHALL hold state=IDLE, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, busy_o=0, err_o=0, and all counters at 0.
REQ-033 Reset asserted mid-frame SHALL abort immediately with no write pulse, and SHALL restart cleanly at IDLE.

Verification
REQ-034 The bench SHALL cover: bytes 02 00 78 56 34 12 EF BE AD DE -> wen pulses adr0=0x12345678, adr1=0xDEADBEEF; done=1 one cycle after the 2nd pulse.
REQ-035 The bench SHALL cover: count 00 00 -> err_o=1, no wen, return to IDLE; a following legal frame clears err_o and writes.
REQ-036 The bench SHALL cover: count 01 40 (N=16385, ADDR_W=14) -> err_o=1, no writes.
REQ-037 The bench SHALL cover: N=1, 2 data bytes, then TIMEOUT idle cycles -> err_o=1, IDLE, no wen, done=0; a byte landing exactly on cycle TIMEOUT-1 is accepted, with no error.
REQ-038 The bench SHALL cover: N=3 with all bytes back-to-back every cycle -> 3 wen pulses exactly 4 cycles apart, adr 0,1,2, upg_dat_o stable between pulses.
REQ-039 The bench SHALL cover: reset low after 5 data bytes -> all outputs 0; after release, a fresh frame starts at adr 0; bytes sent in DONE produce no wen.

Source files
------------

// File: rtl/upg_word_writer.sv
// Byte-stream program-memory writer: frames are a 16-bit word count followed by
// little-endian 32-bit words, each written out as a one-cycle write pulse.
module upg_word_writer #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic              upg_clk_i,
    input  logic              upg_rstn_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StCntHi, StData, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       asm_q, asm_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              last_q, last_d;

    logic [15:0] n_word;
    logic        n_legal;
    logic [31:0] asm_next;
    logic        busy;
    logic        tmo_hit;

    assign n_word   = {rx_data_i, cnt_lo_q};
    assign n_legal  = (n_word != 16'd0) && (32'(n_word) <= (32'd1 << ADDR_W));
    assign asm_next = {rx_data_i, asm_q[31:8]};
    assign busy     = (state_q == StCntHi) || (state_q == StData);
    // A byte arriving on the final cycle wins over the timeout.
    assign tmo_hit  = (tmo_q == TMO_MAX) && !rx_valid_i;

    always_comb begin
        state_d    = state_q;
        cnt_lo_d   = cnt_lo_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        wen_d      = 1'b0;
        adr_d      = adr_q;
        dat_d      = dat_q;
        done_d     = done_q;
        err_d      = err_q;
        last_d     = last_q;

        unique case (state_q)
            StIdle: begin
                if (rx_valid_i) begin
                    cnt_lo_d = rx_data_i;
                    err_d    = 1'b0;
                    state_d  = StCntHi;
                end
            end
            StCntHi: begin
                if (rx_valid_i) begin
                    if (n_legal) begin
                        cnt_d      = n_word;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        adr_d      = '0;
                        last_d     = 1'b0;
                        state_d    = StData;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StData: begin
                // Stay in DATA through the final write pulse so wen never shows in DONE.
                if (wen_q && last_q) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (rx_valid_i) begin
                    asm_d      = asm_next;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wen_d      = 1'b1;
                        dat_d      = asm_next;
                        adr_d      = word_idx_q;
                        word_idx_d = word_idx_q + ADDR_W'(1);
                        last_d     = (32'(word_idx_q) == (32'(cnt_q) - 32'd1));
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tmo_d = '0;
        if (busy && (state_d == state_q) && !rx_valid_i) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            state_q    <= StIdle;
            cnt_lo_q   <= '0;
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            tmo_q      <= '0;
            wen_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_lo_q   <= cnt_lo_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            tmo_q      <= tmo_d;
            wen_q      <= wen_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            done_q     <= done_d;
            err_q      <= err_d;
            last_q     <= last_d;
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign busy_o     = busy;
    assign err_o      = err_q;

endmodule

// File: tb/tb_upg_word_writer.sv
// Directed bench for upg_word_writer: a table of whole frames plus hand-written
// sequences for timeout, back-to-back streaming and mid-frame reset.
module tb_upg_word_writer;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wen;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
    logic              done;
    logic              busy;
    logic              err;

    upg_word_writer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .upg_clk_i  (clk),
        .upg_rstn_i (rstn),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .upg_wen_o  (wen),
        .upg_adr_o  (adr),
        .upg_dat_o  (dat),
        .upg_done_o (done),
        .busy_o     (busy),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int vec_n  = 0;
    int miss_n = 0;

    // Write-pulse monitor, sampled on the falling edge.
    int                cyc = 0;
    int                wen_n = 0;
    int                done_cyc = -1;
    int                viol = 0;
    logic              done_prev = 1'b0;
    logic [31:0]       last_dat = '0;
    logic [31:0]       mon_dat [64];
    logic [ADDR_W-1:0] mon_adr [64];
    int                mon_cyc [64];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn) begin
            last_dat  = '0;
            done_prev = 1'b0;
        end else begin
            if (wen) begin
                if (wen_n < 64) begin
                    mon_dat[wen_n] = dat;
                    mon_adr[wen_n] = adr;
                    mon_cyc[wen_n] = cyc;
                end
                wen_n    = wen_n + 1;
                last_dat = dat;
            end else if (dat !== last_dat) begin
                viol = viol + 1;
            end
            if (done && !done_prev) done_cyc = cyc;
            done_prev = done;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_n = vec_n + 1;
        if (act !== exp) begin
            miss_n = miss_n + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Byte i of a frame sits at bits [8*i +: 8], so literals read right to left.
    typedef struct {
        string        name;
        int           nb;
        logic [127:0] bytes;
        int           exp_wen;
        logic [31:0]  d0;
        logic [31:0]  d1;
        logic         exp_err;
        logic         exp_done;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          base;
        int          viol0;
        logic [7:0]  b;
        logic [31:0] w;

        vecs[0] = '{"two_words",   10, 128'hDEADBEEF123456780002,   2, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[1] = '{"count_zero",   2, 128'h0000,                   0, 32'h0,        32'h0,        1'b1, 1'b0};
        vecs[2] = '{"count_16385",  2, 128'h4001,                   0, 32'h0,        32'h0,        1'b1, 1'b0};
        vecs[3] = '{"count_32768",  2, 128'h8000,                   0, 32'h0,        32'h0,        1'b1, 1'b0};
        vecs[4] = '{"one_word",     6, 128'h443322110001,           1, 32'h44332211, 32'h0,        1'b0, 1'b1};
        vecs[5] = '{"done_ignore", 10, 128'h88776655DDCCBBAA0001,   1, 32'hDDCCBBAA, 32'h0,        1'b0, 1'b1};

        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", 64'({wen, adr, dat, done, busy, err}), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            base = wen_n;
            for (int i = 0; i < vecs[v].nb; i++) begin
                w = 32'(vecs[v].bytes >> (8 * i));
                b = w[7:0];
                drive(1'b1, b);
            end
            idle(4);
            #1;
            check({vecs[v].name, "_wen_count"}, 64'(wen_n - base), 64'(vecs[v].exp_wen));
            if (vecs[v].exp_wen >= 1) begin
                check({vecs[v].name, "_adr0"}, 64'(mon_adr[base]), 64'd0);
                check({vecs[v].name, "_dat0"}, 64'(mon_dat[base]), 64'(vecs[v].d0));
            end
            if (vecs[v].exp_wen >= 2) begin
                check({vecs[v].name, "_adr1"}, 64'(mon_adr[base + 1]), 64'd1);
                check({vecs[v].name, "_dat1"}, 64'(mon_dat[base + 1]), 64'(vecs[v].d1));
                check({vecs[v].name, "_done_lat"}, 64'(done_cyc - mon_cyc[base + 1]), 64'd1);
            end
            check({vecs[v].name, "_err"}, 64'(err), 64'(vecs[v].exp_err));
            check({vecs[v].name, "_done"}, 64'(done), 64'(vecs[v].exp_done));
            check({vecs[v].name, "_busy"}, 64'(busy), 64'd0);
        end

        // Error from a zero count is cleared by the next frame's first byte.
        do_reset();
        base = wen_n;
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h00);
        idle(1);
        #1;
        check("zero_then_err", 64'({err, busy}), 64'b10);
        drive(1'b1, 8'h01);
        #1;
        check("zero_then_clear", 64'({err, busy}), 64'b01);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h02);
        drive(1'b1, 8'h03);
        drive(1'b1, 8'h04);
        idle(3);
        #1;
        check("zero_then_wen", 64'(wen_n - base), 64'd1);
        check("zero_then_dat", 64'(mon_dat[base]), 64'h04030201);

        // Timeout: still busy after TIMEOUT-1 idle cycles, error after TIMEOUT.
        do_reset();
        base = wen_n;
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        idle(TIMEOUT - 1);
        #1;
        check("tmo_before", 64'({err, busy}), 64'b01);
        idle(1);
        #1;
        check("tmo_after", 64'({err, busy, done}), 64'b100);
        check("tmo_no_wen", 64'(wen_n - base), 64'd0);

        // A byte in the very last allowed cycle is accepted.
        do_reset();
        base = wen_n;
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        idle(TIMEOUT - 1);
        drive(1'b1, 8'h33);
        drive(1'b1, 8'h44);
        idle(3);
        #1;
        check("edge_err", 64'(err), 64'd0);
        check("edge_wen", 64'(wen_n - base), 64'd1);
        check("edge_dat", 64'(mon_dat[base]), 64'h44332211);
        check("edge_done", 64'(done), 64'd1);

        // N=3 streamed one byte per cycle.
        do_reset();
        base  = wen_n;
        viol0 = viol;
        drive(1'b1, 8'h03);
        drive(1'b1, 8'h00);
        for (int i = 0; i < 12; i++) drive(1'b1, 8'(8'h10 + i));
        idle(4);
        #1;
        check("b2b_wen", 64'(wen_n - base), 64'd3);
        check("b2b_adr", 64'({mon_adr[base], mon_adr[base + 1], mon_adr[base + 2]}),
              64'({14'd0, 14'd1, 14'd2}));
        check("b2b_dat0", 64'(mon_dat[base]), 64'h13121110);
        check("b2b_dat1", 64'(mon_dat[base + 1]), 64'h17161514);
        check("b2b_dat2", 64'(mon_dat[base + 2]), 64'h1B1A1918);
        check("b2b_gap01", 64'(mon_cyc[base + 1] - mon_cyc[base]), 64'd4);
        check("b2b_gap12", 64'(mon_cyc[base + 2] - mon_cyc[base + 1]), 64'd4);
        check("b2b_done_lat", 64'(done_cyc - mon_cyc[base + 2]), 64'd1);
        check("b2b_dat_stable", 64'(viol - viol0), 64'd0);

        // Reset mid-frame, then a fresh frame and ignored bytes in DONE.
        do_reset();
        base = wen_n;
        drive(1'b1, 8'h02);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hA1);
        drive(1'b1, 8'hA2);
        drive(1'b1, 8'hA3);
        drive(1'b1, 8'hA4);
        drive(1'b1, 8'hA5);
        rx_valid = 1'b0;
        rstn     = 1'b0;
        #1;
        check("rst_mid_outputs", 64'({wen, adr, dat, done, busy, err}), 64'd0);
        idle(2);
        #1;
        check("rst_mid_held", 64'({wen, adr, dat, done, busy, err}), 64'd0);
        rstn = 1'b1;
        idle(1);
        base = wen_n;
        drive(1'b1, 8'h01);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hC1);
        drive(1'b1, 8'hC2);
        drive(1'b1, 8'hC3);
        drive(1'b1, 8'hC4);
        idle(3);
        #1;
        check("rst_fresh_wen", 64'(wen_n - base), 64'd1);
        check("rst_fresh_adr", 64'(mon_adr[base]), 64'd0);
        check("rst_fresh_dat", 64'(mon_dat[base]), 64'hC4C3C2C1);
        for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'hE0 + i));
        idle(3);
        #1;
        check("done_no_wen", 64'(wen_n - base), 64'd1);
        check("done_held", 64'({done, busy}), 64'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule
